la_capture_core: RTL and testbench

Parametrised logic-analyser capture engine that supersedes the fixed 3-probe, single-trigger SPI probe core. It samples CH_W probe channels into a circular buffer with a programmable pre-trigger depth and four trigger modes. After capture it streams the window out in chronological order over a valid/ready port to the debug readout logic, such as a JTAG bridge or UART dumper.

---
 rtl/la_pkg.sv | 23 ++
 rtl/la_sample_ram.sv | 34 +++
 rtl/la_capture_core.sv | 275 +++++++++++++++++++++++++++
 tb/tb_la_capture_core.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared definitions for the la_capture_core logic-analyser slice.
// Holds the FSM state values (as reported on state_o), trigger modes and default sizes.
package la_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_READ = 3'd4
    } la_state_e;

    typedef enum logic [1:0] {
        TRIG_IMM   = 2'b00,
        TRIG_LEVEL = 2'b01,
        TRIG_RISE  = 2'b10,
        TRIG_FALL  = 2'b11
    } la_trig_mode_e;

    localparam int unsigned LA_DEPTH_DEFAULT = 1024;
    localparam int unsigned LA_TS_W_DEFAULT  = 16;

endpackage

// File: rtl/la_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// No reset on the array or read register so the tools can map it to block RAM.
module la_sample_ram #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: circular pre/post-trigger buffer streamed out over valid/ready.
// Define LA_TIMESTAMP_EN to store a free-running TS_W-bit cycle stamp with every sample.
module la_capture_core
    import la_pkg::*;
#(
    parameter int unsigned CH_W   = 3,
    parameter int unsigned DEPTH  = LA_DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned TS_W   = LA_TS_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [CH_W-1:0]   data_i,
    input  logic              sample_en_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] pretrig_i,
    input  logic [1:0]        trig_mode_i,
    input  logic [CH_W-1:0]   trig_mask_i,
    input  logic [CH_W-1:0]   trig_value_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
`ifdef LA_TIMESTAMP_EN
    output logic [TS_W+CH_W-1:0] rd_data_o,
`else
    output logic [CH_W-1:0]   rd_data_o,
`endif
    output logic              rd_last_o,
    output logic [2:0]        state_o,
    output logic              trig_seen_o
);

`ifdef LA_TIMESTAMP_EN
    localparam int unsigned DATA_W = TS_W + CH_W;
`else
    // TS_W only widens the stored word when timestamps are built in.
    localparam int unsigned DATA_W = CH_W + 0 * TS_W;
`endif
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    la_state_e         state_q, state_d;
    la_trig_mode_e     mode_q, mode_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, pre_q, pre_d, trig_addr_q, trig_addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d, rd_cnt_q, rd_cnt_d;
    logic [CH_W-1:0]   mask_q, mask_d, value_q, value_d;
    logic              prev_match_q, prev_match_d, have_prev_q, have_prev_d;
    logic              trig_seen_q, trig_seen_d;
    logic              inflight_q, inflight_d, inflight_last_q, inflight_last_d;
    logic              out_v_q, out_v_d, out_last_q, out_last_d;
    logic              skid_v_q, skid_v_d, skid_last_q, skid_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;

    logic [DATA_W-1:0] wdata, ram_rdata;
    logic [ADDR_W:0]   post;
    logic [ADDR_W-1:0] raddr;
    logic [1:0]        occ;
    logic              match, trig_hit, arm_go, xfer, issue, issue_last, we;

    assign arm_go = arm_i & ~abort_i & (state_q == ST_IDLE);
    assign post   = DEPTH_C - {1'b0, pre_q};
    assign xfer   = out_v_q & rd_ready_i;
    assign raddr  = trig_addr_q - pre_q + rd_cnt_q[ADDR_W-1:0];

`ifdef LA_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;
    assign ts_d  = arm_go ? '0 : ts_q + TS_W'(1);
    assign wdata = {ts_q, data_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ts_q <= '0;
        else          ts_q <= ts_d;
    end
`else
    assign wdata = data_i;
`endif

    always_comb begin
        match = ((data_i & mask_q) == (value_q & mask_q));
        case (mode_q)
            TRIG_IMM:   trig_hit = 1'b1;
            TRIG_LEVEL: trig_hit = match;
            TRIG_RISE:  trig_hit = have_prev_q & match & ~prev_match_q;
            default:    trig_hit = have_prev_q & ~match & prev_match_q;
        endcase
    end

    // Credit check: out + skid + in-flight read must never exceed two words.
    always_comb begin
        occ        = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, inflight_q} - {1'b0, xfer};
        issue      = (state_q == ST_READ) && !rd_cnt_q[ADDR_W] && (occ < 2'd2);
        issue_last = (rd_cnt_q == DEPTH_C - CNT_ONE);
    end

    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        wr_ptr_d        = wr_ptr_q;
        pre_d           = pre_q;
        trig_addr_d     = trig_addr_q;
        cnt_d           = cnt_q;
        rd_cnt_d        = rd_cnt_q + (issue ? CNT_ONE : '0);
        mask_d          = mask_q;
        value_d         = value_q;
        prev_match_d    = prev_match_q;
        have_prev_d     = have_prev_q;
        trig_seen_d     = trig_seen_q;
        inflight_d      = issue;
        inflight_last_d = issue_last;
        out_v_d         = out_v_q;
        out_last_d      = out_last_q;
        out_data_d      = out_data_q;
        skid_v_d        = skid_v_q;
        skid_last_d     = skid_last_q;
        skid_data_d     = skid_data_q;
        we              = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm_go) begin
                    mode_d       = la_trig_mode_e'(trig_mode_i);
                    pre_d        = pretrig_i;
                    mask_d       = trig_mask_i;
                    value_d      = trig_value_i;
                    wr_ptr_d     = '0;
                    trig_addr_d  = '0;
                    cnt_d        = '0;
                    rd_cnt_d     = '0;
                    have_prev_d  = 1'b0;
                    prev_match_d = 1'b0;
                    trig_seen_d  = 1'b0;
                    state_d      = (pretrig_i != '0) ? ST_PRE : ST_WAIT;
                end
            end
            ST_PRE: begin
                if (sample_en_i) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    cnt_d    = cnt_q + CNT_ONE;
                    if (cnt_q + CNT_ONE == {1'b0, pre_q}) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (sample_en_i) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (trig_hit) begin
                        trig_addr_d = wr_ptr_q;
                        trig_seen_d = 1'b1;
                        cnt_d       = CNT_ONE;
                        state_d     = (post == CNT_ONE) ? ST_READ : ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (sample_en_i) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    cnt_d    = cnt_q + CNT_ONE;
                    if (cnt_q + CNT_ONE == post) state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (xfer && out_last_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Edge detection spans PRE too, so the first WAIT sample already has a predecessor.
        if (sample_en_i && (state_q == ST_PRE || state_q == ST_WAIT || state_q == ST_POST)) begin
            prev_match_d = match;
            have_prev_d  = 1'b1;
        end

        if (!out_v_q || xfer) begin
            if (skid_v_q) begin
                out_v_d     = 1'b1;
                out_data_d  = skid_data_q;
                out_last_d  = skid_last_q;
                skid_v_d    = inflight_q;
                skid_data_d = ram_rdata;
                skid_last_d = inflight_last_q;
            end else if (inflight_q) begin
                out_v_d    = 1'b1;
                out_data_d = ram_rdata;
                out_last_d = inflight_last_q;
            end else begin
                out_v_d = 1'b0;
            end
        end else if (inflight_q) begin
            skid_v_d    = 1'b1;
            skid_data_d = ram_rdata;
            skid_last_d = inflight_last_q;
        end

        if (abort_i) begin
            state_d     = ST_IDLE;
            trig_seen_d = 1'b0;
            inflight_d  = 1'b0;
            out_v_d     = 1'b0;
            out_last_d  = 1'b0;
            skid_v_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= ST_IDLE;
            mode_q          <= TRIG_IMM;
            wr_ptr_q        <= '0;
            pre_q           <= '0;
            trig_addr_q     <= '0;
            cnt_q           <= '0;
            rd_cnt_q        <= '0;
            mask_q          <= '0;
            value_q         <= '0;
            prev_match_q    <= 1'b0;
            have_prev_q     <= 1'b0;
            trig_seen_q     <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            out_v_q         <= 1'b0;
            out_last_q      <= 1'b0;
            out_data_q      <= '0;
            skid_v_q        <= 1'b0;
            skid_last_q     <= 1'b0;
            skid_data_q     <= '0;
        end else begin
            state_q         <= state_d;
            mode_q          <= mode_d;
            wr_ptr_q        <= wr_ptr_d;
            pre_q           <= pre_d;
            trig_addr_q     <= trig_addr_d;
            cnt_q           <= cnt_d;
            rd_cnt_q        <= rd_cnt_d;
            mask_q          <= mask_d;
            value_q         <= value_d;
            prev_match_q    <= prev_match_d;
            have_prev_q     <= have_prev_d;
            trig_seen_q     <= trig_seen_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            out_v_q         <= out_v_d;
            out_last_q      <= out_last_d;
            out_data_q      <= out_data_d;
            skid_v_q        <= skid_v_d;
            skid_last_q     <= skid_last_d;
            skid_data_q     <= skid_data_d;
        end
    end

    la_sample_ram #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .re_i    (issue),
        .raddr_i (raddr),
        .rdata_o (ram_rdata)
    );

    assign state_o     = state_q;
    assign trig_seen_o = trig_seen_q;
    assign rd_valid_o  = out_v_q;
    assign rd_last_o   = out_v_q & out_last_q;
    assign rd_data_o   = out_data_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Randomised bench for la_capture_core (DEPTH=16, CH_W=3) against a sample-list reference model.
module tb_la_capture_core;

    localparam int unsigned CH_W   = 3;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic [CH_W-1:0]   data_i;
    logic              sample_en_i;
    logic              arm_i;
    logic              abort_i;
    logic [ADDR_W-1:0] pretrig_i;
    logic [1:0]        trig_mode_i;
    logic [CH_W-1:0]   trig_mask_i;
    logic [CH_W-1:0]   trig_value_i;
    logic              rd_valid_o;
    logic              rd_ready_i;
    logic [CH_W-1:0]   rd_data_o;
    logic              rd_last_o;
    logic [2:0]        state_o;
    logic              trig_seen_o;

    la_capture_core #(
        .CH_W  (CH_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .data_i       (data_i),
        .sample_en_i  (sample_en_i),
        .arm_i        (arm_i),
        .abort_i      (abort_i),
        .pretrig_i    (pretrig_i),
        .trig_mode_i  (trig_mode_i),
        .trig_mask_i  (trig_mask_i),
        .trig_value_i (trig_value_i),
        .rd_valid_o   (rd_valid_o),
        .rd_ready_i   (rd_ready_i),
        .rd_data_o    (rd_data_o),
        .rd_last_o    (rd_last_o),
        .state_o      (state_o),
        .trig_seen_o  (trig_seen_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Every qualified sample driven since the last arm, in order.
    logic [CH_W-1:0] samples[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    function automatic bit is_match(input logic [CH_W-1:0] s, input int mask, input int value);
        return ((int'(s) & mask) == (value & mask));
    endfunction

    // Index of the trigger sample: first sample past the pre-trigger region satisfying the mode.
    function automatic int find_trig(input int pre, input int mode, input int mask, input int value);
        for (int i = pre; i < samples.size(); i++) begin
            bit cur;
            bit prv;
            cur = is_match(samples[i], mask, value);
            prv = (i > 0) ? is_match(samples[i-1], mask, value) : 1'b0;
            case (mode)
                0:       return i;
                1:       if (cur) return i;
                2:       if (i > 0 && cur && !prv) return i;
                default: if (i > 0 && !cur && prv) return i;
            endcase
        end
        return -1;
    endfunction

    task automatic do_abort();
        abort_i = 1'b1;
        cycle();
        abort_i = 1'b0;
    endtask

    // stim: 0 counting 0..7, 1 random, 2 alternating 1,0,...; en_kind: 0 always, 1 toggle, 2 random.
    task automatic run_capture(input string name, input int pre, input int mode, input int mask,
                               input int value, input int stim, input int en_kind,
                               input int ready_pct, input int want_trig);
        int cyc, seen_at, t, k, lasts, idx;
        bit en, stalled;
        logic [CH_W-1:0] d, held_d;
        logic held_l;
        logic [CH_W-1:0] exp_win[$];

        pretrig_i    = ADDR_W'(pre);
        trig_mode_i  = 2'(mode);
        trig_mask_i  = CH_W'(mask);
        trig_value_i = CH_W'(value);
        sample_en_i  = 1'b0;
        data_i       = CH_W'($urandom);
        arm_i        = 1'b1;
        cycle();
        arm_i = 1'b0;
        check_eq({name, "/arm_state"}, 32'(state_o), (pre > 0) ? 32'd1 : 32'd2);
        check_eq({name, "/arm_trig_seen"}, 32'(trig_seen_o), 32'd0);

        samples.delete();
        seen_at = -1;
        cyc = 0;
        while (state_o != 3'd4 && cyc < 400) begin
            case (en_kind)
                0:       en = 1'b1;
                1:       en = (cyc % 2 == 0);
                default: en = ($urandom_range(9) < 7);
            endcase
            case (stim)
                0:       d = CH_W'(samples.size() % 8);
                1:       d = CH_W'($urandom);
                default: d = (samples.size() % 2 == 0) ? CH_W'(1) : CH_W'(0);
            endcase
            sample_en_i = en;
            data_i      = en ? d : CH_W'($urandom);
            cycle();
            if (en) samples.push_back(d);
            if (seen_at < 0 && trig_seen_o) seen_at = samples.size();
            cyc++;
        end

        if (state_o != 3'd4) begin
            check_eq({name, "/reach_read"}, 32'(state_o), 32'd4);
            do_abort();
            return;
        end

        t = find_trig(pre, mode, mask, value);
        check_eq({name, "/trig_pos"}, 32'(seen_at), 32'(t + 1));
        if (want_trig >= 0) check_eq({name, "/trig_pos_plan"}, 32'(seen_at), 32'(want_trig + 1));
        check_eq({name, "/captured"}, 32'(samples.size()), 32'(t + int'(DEPTH) - pre));
        if (t < 0) begin
            do_abort();
            return;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = t - pre + i;
            exp_win.push_back((idx < samples.size()) ? samples[idx] : CH_W'(0));
        end

        stalled = 1'b0;
        k = 0;
        lasts = 0;
        cyc = 0;
        held_d = '0;
        held_l = 1'b0;
        while (k < int'(DEPTH) && cyc < 200) begin
            rd_ready_i  = ($urandom_range(99) < ready_pct);
            sample_en_i = 1'($urandom);
            data_i      = CH_W'($urandom);
            if (stalled) begin
                check_eq({name, "/hold_valid"}, 32'(rd_valid_o), 32'd1);
                check_eq({name, "/hold_data"}, 32'(rd_data_o), 32'(held_d));
                check_eq({name, "/hold_last"}, 32'(rd_last_o), 32'(held_l));
            end
            stalled = 1'b0;
            if (rd_valid_o) begin
                if (rd_ready_i) begin
                    check_eq($sformatf("%s/word%0d", name, k), 32'(rd_data_o), 32'(exp_win[k]));
                    check_eq($sformatf("%s/last%0d", name, k), 32'(rd_last_o), 32'(k == int'(DEPTH) - 1));
                    if (rd_last_o) lasts++;
                    k++;
                end else begin
                    stalled = 1'b1;
                    held_d  = rd_data_o;
                    held_l  = rd_last_o;
                end
            end
            cycle();
            cyc++;
        end
        rd_ready_i  = 1'b0;
        sample_en_i = 1'b0;
        check_eq({name, "/word_count"}, 32'(k), 32'(DEPTH));
        check_eq({name, "/last_count"}, 32'(lasts), 32'd1);
        check_eq({name, "/end_state"}, 32'(state_o), 32'd0);
        check_eq({name, "/end_valid"}, 32'(rd_valid_o), 32'd0);
        check_eq({name, "/end_trig_seen"}, 32'(trig_seen_o), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "/state"}, 32'(state_o), 32'd0);
        check_eq({name, "/valid"}, 32'(rd_valid_o), 32'd0);
        check_eq({name, "/last"}, 32'(rd_last_o), 32'd0);
        check_eq({name, "/trig_seen"}, 32'(trig_seen_o), 32'd0);
        check_eq({name, "/data"}, 32'(rd_data_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit quiet_bad;

        rst_n_i      = 1'b0;
        data_i       = '0;
        sample_en_i  = 1'b0;
        arm_i        = 1'b0;
        abort_i      = 1'b0;
        pretrig_i    = '0;
        trig_mode_i  = 2'b00;
        trig_mask_i  = '0;
        trig_value_i = '0;
        rd_ready_i   = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        rst_n_i = 1'b1;
        cycle();
        check_reset_outputs("post_reset");

        // abort beats a simultaneous arm
        arm_i   = 1'b1;
        abort_i = 1'b1;
        cycle();
        arm_i   = 1'b0;
        abort_i = 1'b0;
        check_eq("arm_abort/state", 32'(state_o), 32'd0);

        run_capture("level", 4, 1, 7, 5, 0, 0, 100, 5);
        run_capture("imm", 0, 0, 7, 0, 1, 0, 100, 0);
        run_capture("rise", 0, 2, 1, 1, 2, 0, 100, 2);
        run_capture("fall", 3, 3, 1, 1, 2, 0, 50, 3);
        run_capture("en_toggle", 2, 1, 6, 4, 1, 1, 50, -1);
        run_capture("stall", 5, 0, 0, 0, 1, 0, 50, 5);
        run_capture("post_one", 15, 0, 0, 0, 1, 0, 100, 15);

        // abort during POST, with an ignored arm first
        pretrig_i   = 4'd2;
        trig_mode_i = 2'b00;
        arm_i       = 1'b1;
        cycle();
        arm_i = 1'b0;
        cyc = 0;
        while (state_o != 3'd3 && cyc < 20) begin
            sample_en_i = 1'b1;
            data_i      = CH_W'($urandom);
            cycle();
            cyc++;
        end
        check_eq("abort/reach_post", 32'(state_o), 32'd3);
        sample_en_i = 1'b0;
        arm_i       = 1'b1;
        cycle();
        arm_i = 1'b0;
        check_eq("abort/arm_ignored", 32'(state_o), 32'd3);
        do_abort();
        check_eq("abort/state", 32'(state_o), 32'd0);
        check_eq("abort/trig_seen", 32'(trig_seen_o), 32'd0);
        check_eq("abort/valid", 32'(rd_valid_o), 32'd0);
        quiet_bad  = 1'b0;
        rd_ready_i = 1'b1;
        repeat (30) begin
            sample_en_i = 1'($urandom);
            data_i      = CH_W'($urandom);
            cycle();
            if (rd_valid_o || state_o != 3'd0) quiet_bad = 1'b1;
        end
        rd_ready_i = 1'b0;
        check_eq("abort/quiet", 32'(quiet_bad), 32'd0);
        run_capture("rearm", 6, 1, 7, 3, 1, 2, 70, -1);

        // async reset while a readout word is waiting
        pretrig_i   = '0;
        trig_mode_i = 2'b00;
        arm_i       = 1'b1;
        cycle();
        arm_i = 1'b0;
        cyc = 0;
        while (state_o != 3'd4 && cyc < 40) begin
            sample_en_i = 1'b1;
            data_i      = 3'b110;
            cycle();
            cyc++;
        end
        sample_en_i = 1'b0;
        check_eq("rst/reach_read", 32'(state_o), 32'd4);
        repeat (2) cycle();
        check_eq("rst/read_latency", 32'(rd_valid_o), 32'd1);
        check_eq("rst/first_word", 32'(rd_data_o), 32'd6);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        cycle();

        for (int r = 0; r < 6; r++) begin
            run_capture($sformatf("rnd%0d", r), int'($urandom_range(DEPTH - 1)), int'($urandom_range(3)),
                        int'($urandom_range(7, 1)), int'($urandom_range(7)), 1, 2, 50, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
